// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM built-in self-test: FSM state encoding and pattern codes.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] PatAddr    = 2'b00;
  localparam logic [1:0] PatInvAddr = 2'b01;
  localparam logic [1:0] PatCheck   = 2'b10;
  localparam logic [1:0] PatOnes    = 2'b11;

endpackage

// File: rtl/ram_bist_pat.sv
// Combinational test-pattern generator: expected RAM word for a given pattern code and address.
module ram_bist_pat
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) (
  input  logic [1:0]    i_pat,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] w_addr_ext;
  logic [DW-1:0] w_check;

  // Address zero-extended or truncated to the data width.
  always_comb begin
    w_addr_ext = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (i < AW) w_addr_ext[i] = i_addr[i];
    end
  end

  // Even addresses get ...0101, odd addresses get ...1010.
  always_comb begin
    w_check = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      w_check[i] = ((i % 2) == 0) ? ~i_addr[0] : i_addr[0];
    end
  end

  always_comb begin
    o_data = '0;
    case (i_pat)
      PatAddr:    o_data = w_addr_ext;
      PatInvAddr: o_data = ~w_addr_ext;
      PatCheck:   o_data = w_check;
      PatOnes:    o_data = '1;
      default:    o_data = '0;
    endcase
  end

endmodule

// File: rtl/ram_bist.sv
// RAM BIST controller: writes a pattern to every word, reads it back, and records
// the first failing address and the number of mismatching words.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          START,
  input  logic [1:0]    PAT,
  output logic          WE,
  output logic [AW-1:0] A,
  output logic [DW-1:0] Di,
  input  logic [DW-1:0] Do,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAIL,
  output logic [AW-1:0] FAIL_ADDR,
  output logic [AW:0]   ERR_CNT
);

  localparam logic [AW-1:0] ALast = '1;

  state_e        r_state;
  logic [1:0]    r_pat;
  logic          r_we;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_di;
  logic          r_busy;
  logic          r_done;
  logic          r_fail;
  logic [AW-1:0] r_fail_addr;
  logic [AW:0]   r_err_cnt;

  logic [1:0]    w_wr_pat;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic          w_cmp_vld;
  logic [AW-1:0] w_cmp_addr;
  logic [DW-1:0] w_cmp_exp;
  logic          w_mismatch;

  // Write data is registered, so the pattern is computed for the address about to be issued.
  assign w_wr_pat  = (r_state == StWrite) ? r_pat : PAT;
  assign w_wr_addr = (r_state == StWrite) ? r_a + 1'b1 : '0;

  ram_bist_pat #(
    .AW(AW),
    .DW(DW)
  ) u_pat_wr (
    .i_pat (w_wr_pat),
    .i_addr(w_wr_addr),
    .o_data(w_wr_data)
  );

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign w_cmp_vld  = (r_state == StRead);
      assign w_cmp_addr = r_a;
    end else begin : g_lat1
      logic          r_cmp_vld;
      logic [AW-1:0] r_cmp_addr;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          r_cmp_vld  <= 1'b0;
          r_cmp_addr <= '0;
        end else begin
          r_cmp_vld  <= (r_state == StRead);
          r_cmp_addr <= r_a;
        end
      end

      assign w_cmp_vld  = r_cmp_vld;
      assign w_cmp_addr = r_cmp_addr;
    end
  endgenerate

  ram_bist_pat #(
    .AW(AW),
    .DW(DW)
  ) u_pat_cmp (
    .i_pat (r_pat),
    .i_addr(w_cmp_addr),
    .o_data(w_cmp_exp)
  );

  assign w_mismatch = w_cmp_vld && (Do != w_cmp_exp);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= StIdle;
      r_pat       <= PatAddr;
      r_we        <= 1'b0;
      r_a         <= '0;
      r_di        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (START) begin
            r_state     <= StWrite;
            r_pat       <= PAT;
            r_we        <= 1'b1;
            r_a         <= '0;
            r_di        <= w_wr_data;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_err_cnt   <= '0;
          end
        end
        StWrite: begin
          if (r_a == ALast) begin
            r_state <= StRead;
            r_we    <= 1'b0;
            r_a     <= '0;
            r_di    <= '0;
          end else begin
            r_a  <= r_a + 1'b1;
            r_di <= w_wr_data;
          end
        end
        StRead: begin
          if (r_a == ALast) begin
            r_a <= '0;
            if (RD_LAT == 0) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StDrain;
            end
          end else begin
            r_a <= r_a + 1'b1;
          end
        end
        StDrain: begin
          r_state <= StDone;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase

      // Compares only occur in READ/DRAIN, never on a START-accept edge.
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= w_cmp_addr;
        end
      end
    end
  end

  assign WE        = r_we;
  assign A         = r_a;
  assign Di        = r_di;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign FAIL      = r_fail;
  assign FAIL_ADDR = r_fail_addr;
  assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: one instance with a registered-read RAM, one with a combinational-read RAM.
module tb_ram_bist;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       start1, start0;
  logic [1:0] pat;

  logic       we1, we0, busy1, busy0, done1, done0, fail1, fail0;
  logic [3:0] a1, a0, di1, di0, do1, do0, fa1, fa0;
  logic [4:0] ec1, ec0;

  int total = 0;
  int bad   = 0;

  logic [3:0] stuck_mask = 4'h0;
  int         corrupt_addr = -1;
  logic [3:0] mem1 [16];
  logic [3:0] mem0 [16];
  logic [3:0] wa_q [$];
  logic [3:0] wd_q [$];

  always #5 CLK = ~CLK;

  ram_bist #(.AW(4), .DW(4), .RD_LAT(1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .START(start1), .PAT(pat), .WE(we1), .A(a1), .Di(di1), .Do(do1),
    .BUSY(busy1), .DONE(done1), .FAIL(fail1), .FAIL_ADDR(fa1), .ERR_CNT(ec1)
  );

  ram_bist #(.AW(4), .DW(4), .RD_LAT(0)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .START(start0), .PAT(pat), .WE(we0), .A(a0), .Di(di0), .Do(do0),
    .BUSY(busy0), .DONE(done0), .FAIL(fail0), .FAIL_ADDR(fa0), .ERR_CNT(ec0)
  );

  // Fault model applied on the read side of both RAMs.
  function automatic logic [3:0] faulty(input logic [3:0] d, input logic [3:0] a);
    logic [3:0] r;
    r = d & ~stuck_mask;
    if (corrupt_addr >= 0 && int'(a) == corrupt_addr) r = 4'h0;
    return r;
  endfunction

  function automatic logic [3:0] exp_pat(input int p, input int a);
    case (p)
      0:       return 4'(a);
      1:       return 4'(15 - a);
      2:       return (a % 2 == 0) ? 4'd5 : 4'd10;
      default: return 4'd15;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (we1) begin
      mem1[a1] <= di1;
      wa_q.push_back(a1);
      wd_q.push_back(di1);
    end
    do1 <= faulty(mem1[a1], a1);
  end

  always @(posedge CLK) begin
    if (we0) mem0[a0] <= di0;
  end

  always_comb do0 = faulty(mem0[a0], a0);

  // Reference outcome of a full run, from the per-address expected/read values.
  task automatic model(input int p, output int ecnt, output int faddr, output bit ffail);
    ecnt = 0; faddr = 0; ffail = 1'b0;
    for (int a = 0; a < 16; a++) begin
      if (faulty(exp_pat(p, a), 4'(a)) != exp_pat(p, a)) begin
        if (!ffail) faddr = a;
        ffail = 1'b1;
        ecnt++;
      end
    end
  endtask

  // Starts a run on the selected instance and returns the START-to-DONE cycle count.
  task automatic run(input int sel, input logic [1:0] p, output int cyc);
    @(negedge CLK);
    wa_q.delete();
    wd_q.delete();
    pat = p;
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge CLK);
    cyc = 1;
    #1;
    start1 = 1'b0;
    start0 = 1'b0;
    while (((sel == 1) ? done1 : done0) == 1'b0 && cyc < 100) begin
      @(posedge CLK);
      cyc++;
      #1;
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; start1 = 1'b0; start0 = 1'b0; pat = 2'b00;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({we1, a1, di1, busy1, done1, fail1, fa1, ec1} !== 21'h0) begin
      bad++;
      $display("FAIL reset_dut1 got=%h want=0", {we1, a1, di1, busy1, done1, fail1, fa1, ec1});
    end
    total++;
    if ({we0, a0, di0, busy0, done0, fail0, fa0, ec0} !== 21'h0) begin
      bad++;
      $display("FAIL reset_dut0 got=%h want=0", {we0, a0, di0, busy0, done0, fail0, fa0, ec0});
    end
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_pat00_clean();
    int cyc;
    int wbad;
    stuck_mask = 4'h0; corrupt_addr = -1;
    run(1, 2'b00, cyc);
    total++;
    if (cyc !== 34) begin bad++; $display("FAIL pat00_cycles got=%0d want=34", cyc); end
    wbad = 0;
    if (wa_q.size() != 16) wbad = 1;
    else for (int i = 0; i < 16; i++)
      if (wa_q[i] !== 4'(i) || wd_q[i] !== exp_pat(0, i)) wbad = 1;
    total++;
    if (wbad != 0) begin
      bad++;
      $display("FAIL pat00_writes got=%0d writes/bad=%0d want=16 writes of data=addr", wa_q.size(), wbad);
    end
    total++;
    if ({fail1, ec1} !== 6'h0) begin
      bad++;
      $display("FAIL pat00_result got fail=%0b cnt=%0d want fail=0 cnt=0", fail1, ec1);
    end
    total++;
    if ({busy1, done1, we1, a1} !== 7'b0100000) begin
      bad++;
      $display("FAIL pat00_done_state got busy=%0b done=%0b we=%0b a=%0d want 0 1 0 0",
               busy1, done1, we1, a1);
    end
  endtask

  task automatic test_stuck_bit2();
    int cyc, ecnt, faddr;
    bit ffail;
    stuck_mask = 4'b0100; corrupt_addr = -1;
    model(2, ecnt, faddr, ffail);
    run(1, 2'b10, cyc);
    total++;
    if (fail1 !== ffail || fa1 !== 4'(faddr) || ec1 !== 5'(ecnt) || ec1 !== 5'd8) begin
      bad++;
      $display("FAIL stuck_bit2 got fail=%0b addr=%0d cnt=%0d want 1 %0d %0d",
               fail1, fa1, ec1, faddr, ecnt);
    end
  endtask

  task automatic test_corrupt9();
    int cyc, ecnt, faddr;
    bit ffail;
    stuck_mask = 4'h0; corrupt_addr = 9;
    model(3, ecnt, faddr, ffail);
    run(1, 2'b11, cyc);
    total++;
    if (fail1 !== 1'b1 || fa1 !== 4'd9 || ec1 !== 5'(ecnt)) begin
      bad++;
      $display("FAIL corrupt9 got fail=%0b addr=%0d cnt=%0d want 1 9 %0d", fail1, fa1, ec1, ecnt);
    end
  endtask

  task automatic test_rdlat0();
    int cyc;
    stuck_mask = 4'h0; corrupt_addr = -1;
    run(0, 2'b01, cyc);
    total++;
    if (cyc !== 33) begin bad++; $display("FAIL rdlat0_cycles got=%0d want=33", cyc); end
    total++;
    if ({fail0, ec0, busy0} !== 7'h0) begin
      bad++;
      $display("FAIL rdlat0_result got fail=%0b cnt=%0d busy=%0b want 0 0 0", fail0, ec0, busy0);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int nwr;
    stuck_mask = 4'h0; corrupt_addr = -1;
    @(negedge CLK);
    wa_q.delete(); wd_q.delete();
    pat = 2'b00; start1 = 1'b1;
    @(posedge CLK); #1;
    start1 = 1'b0;
    n = 0;
    while (!(we1 && a1 == 4'd5) && n < 40) begin
      @(posedge CLK); #1; n++;
    end
    total++;
    if (!(we1 && a1 == 4'd5)) begin bad++; $display("FAIL midrun_reach_a5 got a=%0d want 5", a1); end
    #1;
    RSTn = 1'b0;
    nwr = wa_q.size();
    #1;
    total++;
    if ({we1, a1, di1, busy1, done1, fail1, fa1, ec1} !== 21'h0) begin
      bad++;
      $display("FAIL midrun_async got=%h want=0", {we1, a1, di1, busy1, done1, fail1, fa1, ec1});
    end
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    total++;
    if (wa_q.size() != nwr || {we1, busy1, done1, a1} !== 7'h0) begin
      bad++;
      $display("FAIL midrun_idle got writes=%0d busy=%0b a=%0d want writes=%0d busy=0 a=0",
               wa_q.size(), busy1, a1, nwr);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    int wbad;
    stuck_mask = 4'h0; corrupt_addr = -1;
    @(negedge CLK);
    wa_q.delete(); wd_q.delete();
    pat = 2'b00; start1 = 1'b1;
    @(posedge CLK); cyc = 1; #1;
    start1 = 1'b0;
    while (!done1 && cyc < 100) begin
      @(posedge CLK); cyc++; #1;
      // START pulses in WRITE, READ and DRAIN with a different pattern
      if (cyc == 5 || cyc == 17 || cyc == 33) begin start1 = 1'b1; pat = 2'b11; end
      else start1 = 1'b0;
    end
    start1 = 1'b0;
    total++;
    if (cyc !== 34) begin bad++; $display("FAIL ignore_cycles got=%0d want=34", cyc); end
    wbad = 0;
    if (wa_q.size() != 16) wbad = 1;
    else for (int i = 0; i < 16; i++) if (wd_q[i] !== exp_pat(0, i)) wbad = 1;
    total++;
    if (wbad != 0 || ec1 !== 5'd0) begin
      bad++;
      $display("FAIL ignore_data got writes=%0d cnt=%0d want 16 0", wa_q.size(), ec1);
    end
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL done_hold got done=%0b busy=%0b want 1 0", done1, busy1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    stuck_mask = 4'h0; corrupt_addr = 3;
    run(1, 2'b11, cyc);
    total++;
    if (fail1 !== 1'b1 || ec1 !== 5'd1 || fa1 !== 4'd3) begin
      bad++;
      $display("FAIL b2b_first got fail=%0b cnt=%0d addr=%0d want 1 1 3", fail1, ec1, fa1);
    end
    corrupt_addr = -1;
    @(negedge CLK);
    pat = 2'b00; start1 = 1'b1;
    @(posedge CLK); cyc = 1; #1;
    start1 = 1'b0;
    total++;
    if ({fail1, ec1, fa1, done1, busy1} !== 12'b0_00000_0000_01) begin
      bad++;
      $display("FAIL b2b_clear got fail=%0b cnt=%0d addr=%0d done=%0b busy=%0b want 0 0 0 0 1",
               fail1, ec1, fa1, done1, busy1);
    end
    while (!done1 && cyc < 100) begin @(posedge CLK); cyc++; #1; end
    total++;
    if (fail1 !== 1'b0 || ec1 !== 5'd0 || cyc !== 34) begin
      bad++;
      $display("FAIL b2b_second got fail=%0b cnt=%0d cyc=%0d want 0 0 34", fail1, ec1, cyc);
    end
  endtask

  task automatic test_random();
    int cyc, ecnt, faddr, sel;
    bit ffail;
    logic [1:0] p;
    for (int it = 0; it < 10; it++) begin
      sel = it % 2;
      p = 2'($urandom_range(3));
      stuck_mask = ($urandom_range(2) == 0) ? (4'b0001 << $urandom_range(3)) : 4'h0;
      corrupt_addr = ($urandom_range(1) == 0) ? int'($urandom_range(15)) : -1;
      model(int'(p), ecnt, faddr, ffail);
      run(sel, p, cyc);
      total++;
      if (sel == 1) begin
        if (cyc !== 34 || fail1 !== ffail || fa1 !== 4'(faddr) || ec1 !== 5'(ecnt)) begin
          bad++;
          $display("FAIL rand%0d_lat1 got cyc=%0d fail=%0b addr=%0d cnt=%0d want 34 %0b %0d %0d",
                   it, cyc, fail1, fa1, ec1, ffail, faddr, ecnt);
        end
      end else begin
        if (cyc !== 33 || fail0 !== ffail || fa0 !== 4'(faddr) || ec0 !== 5'(ecnt)) begin
          bad++;
          $display("FAIL rand%0d_lat0 got cyc=%0d fail=%0b addr=%0d cnt=%0d want 33 %0b %0d %0d",
                   it, cyc, fail0, fa0, ec0, ffail, faddr, ecnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pat00_clean();
    test_stuck_bit2();
    test_corrupt9();
    test_rdlat0();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
